// File: rtl/sprite_select.sv
// Per-scanline sprite selector: scans OAM word pairs into N_SLOTS line slots,
// then answers renderer queries by screen x in OAM order, consuming each hit.
module sprite_select #(
    parameter int N_SLOTS = 10,
    parameter int N_OAM   = 40,
    parameter int OAM_AW  = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [7:0]                     ly,
    input  logic                           tall,
    output logic [OAM_AW-1:0]              oam_addr,
    input  logic [15:0]                    oam_d,
    output logic                           scan_done,
    output logic [$clog2(N_SLOTS+1)-1:0]   count,
    output logic                           overflow,
    input  logic                           q_valid,
    input  logic [7:0]                     q_x,
    output logic                           hit,
    output logic [7:0]                     hit_tile,
    output logic [2:0]                     hit_row,
    output logic [3:0]                     hit_attrs,
    output logic [2:0]                     hit_skip
);
    localparam int CW = $clog2(N_SLOTS + 1);
    localparam logic [OAM_AW-1:0] LAST_ADDR = OAM_AW'(2 * N_OAM - 1);

    typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;
    state_t state;

    logic [15:0]        word_buf;
    logic [N_SLOTS-1:0] filled;
    logic [N_SLOTS-1:0] consumed;
    logic [8:0]         slot_kx    [N_SLOTS];
    logic [7:0]         slot_tile  [N_SLOTS];
    logic [2:0]         slot_row   [N_SLOTS];
    logic [3:0]         slot_attrs [N_SLOTS];

    // Entry evaluation: word_buf holds {y,x}, oam_d holds {tile,attrs}
    logic [7:0] e_y, e_x, e_tile, e_attrs, dy, tile_adj;
    logic [3:0] row4;
    logic [8:0] e_kx;
    logic       vis;

    always_comb begin
        e_y     = word_buf[15:8];
        e_x     = word_buf[7:0];
        e_tile  = oam_d[15:8];
        e_attrs = oam_d[7:0];
        dy      = ly - e_y + 8'd16;
        vis     = (tall ? (dy < 8'd16) : (dy < 8'd8)) && (e_x != 8'd0) && (e_x < 8'd168);
        if (e_attrs[6])
            row4 = (tall ? 4'd15 : 4'd7) - dy[3:0];
        else
            row4 = dy[3:0];
        tile_adj = tall ? {e_tile[7:1], row4[3]} : e_tile;
        e_kx     = {1'b0, e_x} - 9'd8;
    end

    // Query: lowest-index unconsumed slot whose key matches wins
    logic [N_SLOTS-1:0] match;
    logic [N_SLOTS-1:0] sel;
    logic               found;

    always_comb begin
        for (int unsigned i = 0; i < N_SLOTS; i++)
            match[i] = filled[i] && !consumed[i] &&
                       ((slot_kx[i] == {1'b0, q_x}) || ((q_x == 8'd0) && slot_kx[i][8]));
    end

    always_comb begin
        sel       = '0;
        found     = 1'b0;
        hit_tile  = '0;
        hit_row   = '0;
        hit_attrs = '0;
        hit_skip  = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (match[i] && !found) begin
                found     = 1'b1;
                sel[i]    = 1'b1;
                hit_tile  = slot_tile[i];
                hit_row   = slot_row[i];
                hit_attrs = slot_attrs[i];
                hit_skip  = slot_kx[i][8] ? 3'(9'd0 - slot_kx[i]) : 3'd0;
            end
        end
        hit = found && q_valid && (state == READY);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            oam_addr  <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            scan_done <= 1'b0;
            filled    <= '0;
            consumed  <= '0;
            word_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SCAN;
                        oam_addr <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        filled   <= '0;
                        consumed <= '0;
                    end
                end
                SCAN: begin
                    oam_addr <= oam_addr + 1'b1;
                    if (!oam_addr[0]) begin
                        word_buf <= oam_d;
                    end else if (vis) begin
                        // Slots fill strictly in order, so count is the lowest empty index
                        if (count < CW'(N_SLOTS)) begin
                            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                                if (count == CW'(i)) begin
                                    filled[i]     <= 1'b1;
                                    slot_kx[i]    <= e_kx;
                                    slot_tile[i]  <= tile_adj;
                                    slot_row[i]   <= row4[2:0];
                                    slot_attrs[i] <= e_attrs[7:4];
                                end
                            end
                            count <= count + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    if (oam_addr == LAST_ADDR) begin
                        state     <= READY;
                        scan_done <= 1'b1;
                        oam_addr  <= '0;
                    end
                end
                READY: begin
                    if (start) begin
                        state     <= SCAN;
                        scan_done <= 1'b0;
                        oam_addr  <= '0;
                        count     <= '0;
                        overflow  <= 1'b0;
                        filled    <= '0;
                        consumed  <= '0;
                    end else if (hit) begin
                        consumed <= consumed | sel;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sprite_select.md
Name: sprite_select

Overview:
- Parametrised per-scanline sprite selector for the PPU. It replaces the fixed 10-slot chain.
- During OAM scan it reads N_OAM entries as 16-bit word pairs and keeps up to N_SLOTS sprites visible on line ly, in OAM order.
- During draw the renderer queries it by screen x. It returns sprite fetch data (tile, flipped row, attrs) plus a left-clip skip count for sprites partly off the left edge.
- Adds y-flip, overflow reporting and a slot count.

Parameters:
- N_SLOTS, 10, number of sprite slots per line.
- N_OAM, 40, OAM entries scanned; each entry is two 16-bit words.
- OAM_AW, 7, OAM word address width; must satisfy 2**OAM_AW >= 2*N_OAM.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse: clear slots, begin scan
- ly  in  8  current scanline
- tall  in  1  1 = 8x16 sprites, 0 = 8x8
- oam_addr  out  OAM_AW  OAM word address; registered
- oam_d  in  16  word at oam_addr, same cycle; even word = {y,x}, odd word = {tile,attrs}
- scan_done  out  1  high while in READY
- count  out  $clog2(N_SLOTS+1)  number of slots filled
- overflow  out  1  more than N_SLOTS visible sprites were found on this line
- q_valid  in  1  query strobe
- q_x  in  8  screen x being drawn (0..159)
- hit  out  1  a sprite matches q_x this cycle; combinational
- hit_tile  out  8  tile index, tall-adjusted
- hit_row  out  3  row within the 8-pixel tile, y-flip applied
- hit_attrs  out  4  attrs[7:4]: {priority, yflip, xflip, palette}
- hit_skip  out  3  left-clip pixels to discard; 0 unless the sprite is left-clipped

Behaviour:
- Reset (rst=0): state IDLE; oam_addr=0, count=0, overflow=0, scan_done=0, hit=0; all slots empty. Applies mid-scan and mid-query; the slot fill state is discarded.
- States:
  - IDLE: start leads to SCAN; oam_addr and count are cleared at the same time.
  - SCAN: oam_addr increments every cycle.
    - Even address: latch oam_d into a word buffer.
    - Odd address: assemble the entry as {buffer, oam_d} and evaluate it.
    - After address 2*N_OAM-1 is evaluated, go to READY. Scan lasts exactly 2*N_OAM cycles.
  - READY: scan_done=1. start leads back to SCAN with all slots cleared and overflow cleared.
- start while in SCAN: ignored.
- Visibility: dy = ly - (y - 16), computed mod 256. Visible iff dy < 16 when tall, else dy < 8.
- Row: r = yflip ? (H-1-dy) : dy, where H = 16 or 8 (4-bit value).
  - hit_row = r[2:0].
  - Tall: tile = {tile[7:1], r[3]}; otherwise tile is used unchanged.
- Entries with x == 0 or x >= 168 are treated as not visible.
- Slot fill:
  - A visible entry goes into the lowest-index empty slot and count increments.
  - If all slots are full, the entry is dropped and overflow is set (sticky until the next start or rst).
  - Slots store 9-bit key kx = x - 8, computed in signed 9-bit arithmetic (range -7..159).
- Query, only in READY with q_valid=1:
  - A slot matches if it is filled and either kx == q_x, or (q_x == 0 and kx < 0).
  - hit=1, and the lowest-index matching slot drives hit_* outputs.
  - hit_skip = -kx when kx < 0, else 0.
  - On the next clock edge that slot is marked consumed, so repeated queries at the same x return the remaining matches in OAM order until hit=0.
  - count does not decrement on consume.
- hit=0 when q_valid=0 or state != READY. hit_* outputs are don't-care when hit=0.
- oam_addr wraps to 0 on entering READY.
- Priority: in a cycle where start and q_valid are both high, start wins and no slot is consumed.

Test Plan:
- Single sprite: ly=20, y=32, x=50, tile=0x12, attrs=0x00, tall=0; start, wait 80 cycles.
  - scan_done=1, count=1.
  - Query q_x=42 gives hit=1, tile=0x12, row=4, skip=0.
  - Second query at 42 gives hit=0.
- Overflow: 12 entries all visible on ly=0, x=8..19.
  - count=10, overflow=1.
  - Queries return the first 10 OAM entries only.
  - Entries 11 and 12 never hit.
- Same-x ordering: entries 3, 7, 9 at x=100 with tiles 0xA3, 0xA7, 0xA9.
  - Three consecutive queries at q_x=92 return tiles in order 0xA3, 0xA7, 0xA9.
  - Fourth query gives hit=0.
- Tall + y-flip: tall=1, y=16, tile=0x41, attrs=0x40, ly=3.
  - dy=3 gives r=12: tile=0x41, row=4.
  - With tall=0 and attrs=0x40: row=4, tile=0x41.
- Left clip: x=3 gives hit at q_x=0 with skip=5; x=0 and x=168 never hit.
- Reset mid-scan: rst=0 at cycle 30 of scan.
  - count=0, scan_done=0, oam_addr=0.
  - A new start completes a full 80-cycle scan with correct results.
